// File: rtl/axil_bram_pkg.sv
// -----------------------------------------------------------------------------
// axil_bram_pkg
// Shared definitions for the AXI4-Lite to BRAM controller:
//   state_t      - controller FSM states
//   RESP_OKAY    - AXI response code returned for every transaction
//   RESP_SLVERR  - reserved; the controller never generates an error today
// -----------------------------------------------------------------------------
package axil_bram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_RESP = 3'd2,
    RD_WAIT = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_ctrl.sv
// -----------------------------------------------------------------------------
// axil_bram_ctrl
// AXI4-Lite slave that maps single-beat reads and writes onto one port of an
// external block RAM. Exactly one transaction is in flight at any time; writes
// win over reads when both are offered in the same idle cycle.
//
// Parameters
//   ADDR_WIDTH  BRAM word-address width (byte address bits [ADDR_WIDTH+1:2])
//   DATA_WIDTH  AXI-Lite / BRAM data width
//   RD_LATENCY  BRAM read latency in cycles (1 or 2)
//
// Ports
//   axi_clock            sole clock, rising edge
//   rst                  asynchronous active-high reset
//   axil_aw*/axil_w*     write address / write data channels
//   axil_b*              write response channel (always OKAY)
//   axil_ar*/axil_r*     read address / read data channels (always OKAY)
//   bram_addr/din/we/en  BRAM port controls, driven combinationally
//   bram_dout            BRAM read data
// -----------------------------------------------------------------------------
module axil_bram_ctrl
  import axil_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  // write address
  input  logic [31:0]             axil_awaddr,
  input  logic [2:0]              axil_awprot,
  input  logic                    axil_awvalid,
  output logic                    axil_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] axil_wstrb,
  input  logic                    axil_wvalid,
  output logic                    axil_wready,
  // write response
  output logic [1:0]              axil_bresp,
  output logic                    axil_bvalid,
  input  logic                    axil_bready,
  // read address
  input  logic [31:0]             axil_araddr,
  input  logic [2:0]              axil_arprot,
  input  logic                    axil_arvalid,
  output logic                    axil_arready,
  // read data
  output logic [DATA_WIDTH-1:0]   axil_rdata,
  output logic [1:0]              axil_rresp,
  output logic                    axil_rvalid,
  input  logic                    axil_rready,
  // BRAM port
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_din,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic                    bram_en,
  input  logic [DATA_WIDTH-1:0]   bram_dout
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Extra RD_WAIT cycles beyond the first: 0 for latency 1, 1 for latency 2.
  localparam logic RD_WAIT_EXTRA = (RD_LATENCY == 2);

  state_t                  state_q, state_d;
  logic                    aw_done_q, w_done_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rd_cnt_q;

  logic                    aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]   aw_word, ar_word;

  // Byte address bits below the word and above the BRAM depth are dropped, so
  // out-of-range addresses alias modulo the BRAM size.
  assign aw_word = axil_awaddr[ADDR_WIDTH+1:2];
  assign ar_word = axil_araddr[ADDR_WIDTH+1:2];

  assign aw_hs = axil_awvalid & axil_awready;
  assign w_hs  = axil_wvalid  & axil_wready;
  assign ar_hs = axil_arvalid & axil_arready;

  // Protection bits and the ignored address bits are deliberately unused.
  logic unused_ok;
  assign unused_ok = ^{axil_awprot, axil_arprot, axil_awaddr, axil_araddr};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // A capture made in this very cycle counts, so AW+W together go
        // straight to WRITE.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WRITE;
        end else if (ar_hs) begin
          state_d = RD_WAIT;
        end
      end
      WRITE:   state_d = WR_RESP;
      WR_RESP: if (axil_bready) state_d = IDLE;
      RD_WAIT: if (rd_cnt_q == 1'b0) state_d = RD_RESP;
      RD_RESP: if (axil_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    axil_awready = 1'b0;
    axil_wready  = 1'b0;
    axil_arready = 1'b0;
    axil_bvalid  = 1'b0;
    axil_rvalid  = 1'b0;
    bram_en      = 1'b0;
    bram_we      = '0;
    bram_addr    = addr_q;
    unique case (state_q)
      IDLE: begin
        // Readies are gated by rst so they read 0 for the whole reset pulse.
        axil_awready = !rst && !aw_done_q;
        axil_wready  = !rst && !w_done_q;
        // Reads are only offered when no part of a write is present or held.
        axil_arready = !rst && !aw_done_q && !w_done_q &&
                       !axil_awvalid && !axil_wvalid;
        if (axil_arvalid && axil_arready) begin
          bram_en   = 1'b1;
          bram_addr = ar_word;
        end
      end
      WRITE: begin
        bram_en = 1'b1;
        bram_we = wstrb_q;
      end
      WR_RESP: axil_bvalid = 1'b1;
      // Keep the port enabled (address held) so a pipelined BRAM output
      // register advances during the wait.
      RD_WAIT: bram_en = 1'b1;
      RD_RESP: axil_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign bram_din   = wdata_q;
  assign axil_rdata = rdata_q;
  assign axil_bresp = RESP_OKAY;
  assign axil_rresp = RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Datapath: channel captures, read wait counter, read data register
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rd_cnt_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_done_q <= 1'b1;
        addr_q    <= aw_word;
      end
      if (w_hs) begin
        w_done_q <= 1'b1;
        wdata_q  <= axil_wdata;
        wstrb_q  <= axil_wstrb;
      end
      // ar_hs cannot coincide with aw_hs, so addr_q has a single writer per cycle.
      if (ar_hs) begin
        addr_q   <= ar_word;
        rd_cnt_q <= RD_WAIT_EXTRA;
      end
      if (state_q == RD_WAIT) begin
        if (rd_cnt_q == 1'b0) begin
          rdata_q <= bram_dout;
        end else begin
          rd_cnt_q <= 1'b0;
        end
      end
      if (state_q == WR_RESP && axil_bready) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

endmodule
